// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern generator: display modes and bounce direction.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'b00,
        MODE_ROT_R  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_L = 1'b0,
        DIR_R = 1'b1
    } dir_e;

endpackage

// File: rtl/led_pattern_gen_tick.sv
// Prescaler for the LED pattern generator: pulses tick combinationally on the
// enabled cycle where the counter wraps from PERIOD-1 back to 0.
module led_tick_gen #(
    parameter int PERIOD = 500,
    parameter int CNT_W  = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] r_cnt;

    // A clear in the same cycle wins, so no tick may escape alongside it.
    assign tick = en && !clr && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate-left/right, bounce or blink, advanced once per
// prescaler period. Define LED_PATTERN_GEN_ACTIVE_LOW_EN to drive led inverted.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int LED_W  = 16,
    parameter int PERIOD = 500,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led,
    output logic             step
);

    mode_e            r_mode;
    dir_e             r_dir;
    logic [LED_W-1:0] r_pat;
    logic             r_step;

    mode_e            w_mode_in;
    logic             w_mode_chg;
    logic             w_tick;
    mode_e            w_mode_nxt;
    dir_e             w_dir_nxt;
    logic [LED_W-1:0] w_pat_nxt;
    logic             w_step_nxt;
    logic [LED_W-1:0] w_bounce;

    function automatic logic [LED_W-1:0] f_seed(input mode_e m);
        if (m == MODE_BLINK) begin
            return '1;
        end
        return LED_W'(1);
    endfunction

    // Written as shift/or pairs so that LED_W = 1 degenerates to a hold.
    function automatic logic [LED_W-1:0] f_rotl(input logic [LED_W-1:0] p);
        return (p << 1) | (p >> (LED_W - 1));
    endfunction

    function automatic logic [LED_W-1:0] f_rotr(input logic [LED_W-1:0] p);
        return (p >> 1) | (p << (LED_W - 1));
    endfunction

    assign w_mode_in  = mode_e'(mode);
    assign w_mode_chg = (w_mode_in != r_mode);

    led_tick_gen #(
        .PERIOD(PERIOD),
        .CNT_W (CNT_W)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (w_mode_chg),
        .tick(w_tick)
    );

    always_comb begin
        w_bounce = r_pat;
        if (LED_W > 1) begin
            w_bounce = (r_dir == DIR_L) ? (r_pat << 1) : (r_pat >> 1);
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        w_dir_nxt  = r_dir;
        w_pat_nxt  = r_pat;
        w_step_nxt = 1'b0;
        if (w_mode_chg) begin
            w_mode_nxt = w_mode_in;
            w_dir_nxt  = DIR_L;
            w_pat_nxt  = f_seed(w_mode_in);
        end else if (w_tick) begin
            w_step_nxt = 1'b1;
            case (r_mode)
                MODE_ROT_L: w_pat_nxt = f_rotl(r_pat);
                MODE_ROT_R: w_pat_nxt = f_rotr(r_pat);
                MODE_BOUNCE: begin
                    w_pat_nxt = w_bounce;
                    // Turn around on arrival at an end, so the ends are not repeated.
                    if (w_bounce[LED_W-1]) begin
                        w_dir_nxt = DIR_R;
                    end else if (w_bounce[0]) begin
                        w_dir_nxt = DIR_L;
                    end
                end
                MODE_BLINK: w_pat_nxt = ~r_pat;
                default:    w_pat_nxt = r_pat;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= MODE_ROT_L;
            r_dir  <= DIR_L;
            r_pat  <= LED_W'(1);
            r_step <= 1'b0;
        end else begin
            r_mode <= w_mode_nxt;
            r_dir  <= w_dir_nxt;
            r_pat  <= w_pat_nxt;
            r_step <= w_step_nxt;
        end
    end

    assign step = r_step;

`ifdef LED_PATTERN_GEN_ACTIVE_LOW_EN
    assign led = ~r_pat;
`else
    assign led = r_pat;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios plus randomized en/mode/reset
// traffic checked against an index-based behavioural model.
module tb_led_pattern_gen;

    localparam int W = 4;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         rst, en, rst_b, en_b;
    logic [1:0]   mode, mode_b;
    logic [W-1:0] led, led_b;
    logic         step, step_b;

    always #5 clk = ~clk;

    led_pattern_gen #(.LED_W(W), .PERIOD(P), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .led(led), .step(step)
    );

    led_pattern_gen #(.LED_W(W), .PERIOD(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .led(led_b), .step(step_b)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Model state: lit LED index for one-hot modes, on/off for blink.
    int m_mode, m_cnt, m_pos, m_dir;
    bit m_on, m_step;

    function automatic logic [W-1:0] phys(input logic [W-1:0] p);
`ifdef LED_PATTERN_GEN_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    function automatic logic [W-1:0] m_led();
        logic [W-1:0] p;
        if (m_mode == 3) p = m_on ? {W{1'b1}} : {W{1'b0}};
        else             p = W'(1) << m_pos;
        return phys(p);
    endfunction

    task automatic m_reset();
        m_mode = 0; m_cnt = 0; m_pos = 0; m_dir = 0; m_on = 1'b1; m_step = 1'b0;
    endtask

    task automatic m_advance();
        case (m_mode)
            0: m_pos = (m_pos + 1) % W;
            1: m_pos = (m_pos + W - 1) % W;
            2: if (W > 1) begin
                   m_pos = m_pos + ((m_dir == 1) ? -1 : 1);
                   if (m_pos == W - 1)  m_dir = 1;
                   else if (m_pos == 0) m_dir = 0;
               end
            default: m_on = !m_on;
        endcase
    endtask

    task automatic m_clock();
        if (rst) begin
            m_reset();
        end else if (int'(mode) != m_mode) begin
            m_mode = int'(mode); m_cnt = 0; m_pos = 0; m_dir = 0; m_on = 1'b1; m_step = 1'b0;
        end else if (en) begin
            if (m_cnt == P - 1) begin
                m_cnt = 0; m_step = 1'b1; m_advance();
            end else begin
                m_cnt = m_cnt + 1; m_step = 1'b0;
            end
        end else begin
            m_step = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        m_clock();
        #1;
        chk({tag, "_led"}, 32'(led), 32'(m_led()));
        chk({tag, "_step"}, 32'(step), 32'(m_step));
    endtask

    logic [W-1:0] bt [8];
    logic [W-1:0] held;

    initial begin
        bt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        rst = 1'b1; en = 1'b1; mode = 2'b00;
        rst_b = 1'b1; en_b = 1'b1; mode_b = 2'b10;
        m_reset();
        #2;
        chk("reset_led", 32'(led), 32'(phys(4'b0001)));
        chk("reset_step", 32'(step), 32'd0);
        chk("reset_led_b", 32'(led_b), 32'(phys(4'b0001)));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rst_b = 1'b0;

        // Rotate-left timing on dut, bounce sequence on dut_b, side by side.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            m_clock();
            #1;
            chk("rotl_led", 32'(led), 32'(m_led()));
            chk("rotl_step", 32'(step), 32'(m_step));
            chk("bounce_led", 32'(led_b), 32'(phys(bt[i])));
            chk("bounce_step", 32'(step_b), (i == 0) ? 32'd0 : 32'd1);
            if (i == 2) chk("rotl_edge3_step", 32'(step), 32'd0);
            if (i == 3) chk("rotl_edge4_led", 32'(led), 32'(phys(4'b0010)));
            if (i == 7) chk("rotl_edge8_led", 32'(led), 32'(phys(4'b0100)));
        end
        for (int i = 0; i < 8; i++) cyc("rotl");
        chk("rotl_edge16_led", 32'(led), 32'(phys(4'b0001)));
        chk("rotl_edge16_step", 32'(step), 32'd1);

        // Pause with the counter at 2.
        cyc("pre_pause"); cyc("pre_pause");
        en = 1'b0;
        held = led;
        for (int i = 0; i < 10; i++) begin
            cyc("pause");
            chk("pause_hold", 32'(led), 32'(held));
        end
        en = 1'b1;
        cyc("resume1");
        chk("resume1_step", 32'(step), 32'd0);
        cyc("resume2");
        chk("resume2_step", 32'(step), 32'd1);
        chk("resume2_led", 32'(led), 32'(phys(4'b0010)));

        // Mode changes.
        for (int i = 0; i < 4; i++) cyc("to_0100");
        chk("at_0100", 32'(led), 32'(phys(4'b0100)));
        mode = 2'b11;
        cyc("blink_load");
        chk("blink_load_led", 32'(led), 32'(phys(4'b1111)));
        chk("blink_load_step", 32'(step), 32'd0);
        for (int i = 0; i < 4; i++) cyc("blink");
        chk("blink_off_led", 32'(led), 32'(phys(4'b0000)));
        chk("blink_off_step", 32'(step), 32'd1);
        mode = 2'b01;
        cyc("rotr_load");
        chk("rotr_load_led", 32'(led), 32'(phys(4'b0001)));
        for (int i = 0; i < 4; i++) cyc("rotr");
        chk("rotr_led", 32'(led), 32'(phys(4'b1000)));

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        chk("async_rst_led", 32'(led), 32'(phys(4'b0001)));
        chk("async_rst_step", 32'(step), 32'd0);
        rst = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                #1;
                rst = 1'b1;
                #1;
                m_reset();
                chk("rand_async_rst", 32'(led), 32'(m_led()));
                rst = 1'b0;
            end
            cyc("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
